cbm2_cycle_sequencer: RTL and testbench

Parametrised system-bus cycle sequencer for the CBM-II core. It divides each bus frame of clk_sys into SLOTS slots of SUBCYC clocks each, plus optional idle padding. It generates the per-slot qualifiers, the 1 MHz phase, the refresh/IO windows, pause gating and the pixel enable. It replaces the hard-coded EXT/CPU/COP/VID(/NOP) enumeration: frame length and per-slot 1/2 MHz behaviour become runtime inputs.

---
 rtl/cbm2_cycle_sequencer.sv | 156 +++++++++++++++
 tb/tb_cbm2_cycle_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cbm2_cycle_sequencer.sv
// cbm2_cycle_sequencer
//   Bus cycle sequencer for the CBM-II core. Each frame of clk_sys is split into SLOTS slots of
//   SUBCYC clocks, optionally followed by idle padding. It produces the per-slot qualifiers,
//   the 1 MHz frame phase, the refresh/IO windows, pause gating and a frame-aligned pixel
//   enable.
//
// Ports
//   clk_sys      system clock
//   reset        synchronous active-high reset
//   frame_len    clocks per frame; latched at frame end, clamped up to SLOTS*SUBCYC
//   slot_fast    per-slot 2 MHz enable (0 = active only in phase 1); latched at frame end
//   pause        pause request, sampled once per refresh period
//   reset_req    system reset request, resynchronised to the frame boundary
//   slot, sub    current slot index and clock within the slot (0 in padding / when disabled)
//   slot_active  one-hot qualified slot
//   slot_first   slot_active on the first clock of the slot
//   slot_last    slot_active on the last clock of the slot
//   padding      frame clock beyond the slot area
//   phase        toggles each enabled frame
//   refresh      one-clock pulse per refresh period
//   io_cycle     slot 0 window available to external SDRAM/IO
//   sys_enable   system running; pause_out is its complement
//   sys_reset    reset_req as seen at the last frame end
//   pixel_en     one pulse every 4 clocks, realigned at each frame start
module cbm2_cycle_sequencer #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SUBCYC   = 4,
  parameter int unsigned FW       = 6,
  parameter int unsigned RFSH_DIV = 8
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [FW-1:0]               frame_len,
  input  logic [SLOTS-1:0]            slot_fast,
  input  logic                        pause,
  input  logic                        reset_req,
  output logic [$clog2(SLOTS)-1:0]    slot,
  output logic [$clog2(SUBCYC)-1:0]   sub,
  output logic [SLOTS-1:0]            slot_active,
  output logic [SLOTS-1:0]            slot_first,
  output logic [SLOTS-1:0]            slot_last,
  output logic                        padding,
  output logic                        phase,
  output logic                        refresh,
  output logic                        io_cycle,
  output logic                        sys_enable,
  output logic                        pause_out,
  output logic                        sys_reset,
  output logic                        pixel_en
);

  localparam int unsigned SlotW = $clog2(SLOTS);
  localparam int unsigned SubW  = $clog2(SUBCYC);
  localparam int unsigned RfW   = $clog2(RFSH_DIV);
  localparam logic [FW-1:0] MinLen = FW'(SLOTS * SUBCYC);
  localparam logic [FW-1:0] SubLen = FW'(SUBCYC);

  logic [FW-1:0]    cyc_q, cyc_d;
  logic [FW-1:0]    len_q, len_d;
  logic [SLOTS-1:0] fast_q, fast_d;
  logic             phase_q, phase_d;
  logic [RfW-1:0]   rfsh_q, rfsh_d;
  logic             en_q, en_d;
  logic             refresh_q, refresh_d;
  logic             sysrst_q, sysrst_d;
  logic [1:0]       pix_q, pix_d;

  logic             frame_end;
  logic             in_slots;
  logic [SlotW-1:0] slot_raw;
  logic [SubW-1:0]  sub_raw;

  assign frame_end = (cyc_q == len_q - FW'(1));
  assign in_slots  = (cyc_q < MinLen);
  assign slot_raw  = cyc_q[SubW +: SlotW];
  assign sub_raw   = cyc_q[SubW-1:0];

  always_comb begin
    cyc_d     = frame_end ? '0 : cyc_q + FW'(1);
    len_d     = len_q;
    fast_d    = fast_q;
    rfsh_d    = rfsh_q;
    en_d      = en_q;
    sysrst_d  = sysrst_q;
    refresh_d = frame_end && (rfsh_q == '0);
    // Disabled system holds phase at 0; the force overrides the frame toggle.
    phase_d   = en_q ? (phase_q ^ frame_end) : 1'b0;
    pix_d     = (!en_q || frame_end) ? 2'd0 : pix_q + 2'd1;
    if (frame_end) begin
      len_d    = (frame_len < MinLen) ? MinLen : frame_len;
      fast_d   = slot_fast;
      rfsh_d   = rfsh_q + RfW'(1);
      sysrst_d = reset_req;
      // pause only takes effect on refresh-period boundaries.
      if (rfsh_q == '0) begin
        en_d = ~pause;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cyc_q     <= '0;
      len_q     <= MinLen;
      fast_q    <= '0;
      phase_q   <= 1'b0;
      rfsh_q    <= '0;
      en_q      <= 1'b0;
      refresh_q <= 1'b0;
      sysrst_q  <= 1'b1;
      pix_q     <= 2'd0;
    end else begin
      cyc_q     <= cyc_d;
      len_q     <= len_d;
      fast_q    <= fast_d;
      phase_q   <= phase_d;
      rfsh_q    <= rfsh_d;
      en_q      <= en_d;
      refresh_q <= refresh_d;
      sysrst_q  <= sysrst_d;
      pix_q     <= pix_d;
    end
  end

  always_comb begin
    slot        = '0;
    sub         = '0;
    slot_active = '0;
    slot_first  = '0;
    slot_last   = '0;
    if (en_q && in_slots) begin
      slot = slot_raw;
      sub  = sub_raw;
      for (int i = 0; i < int'(SLOTS); i++) begin
        slot_active[i] = (slot_raw == SlotW'(i)) && (phase_q || fast_q[i]);
      end
    end
    slot_first = (sub_raw == '0)            ? slot_active : '0;
    slot_last  = (sub_raw == SubW'(SUBCYC - 1)) ? slot_active : '0;
    // The phase-1 EXT slot of the refresh frame belongs to refresh, not IO.
    if (en_q) begin
      io_cycle = (cyc_q < SubLen) && in_slots && (!phase_q || (rfsh_q != '0));
    end else begin
      io_cycle = (cyc_q < SubLen);
    end
  end

  assign padding    = ~in_slots;
  assign phase      = phase_q;
  assign refresh    = refresh_q;
  assign sys_enable = en_q;
  assign pause_out  = ~en_q;
  assign sys_reset  = sysrst_q;
  assign pixel_en   = (pix_q == 2'd3);

endmodule

// File: tb/tb_cbm2_cycle_sequencer.sv
// Directed bench for cbm2_cycle_sequencer with default parameters (4 slots x 4 clocks).
// Clock n means n rising edges after the last edge that saw reset asserted; outputs are
// sampled 1 time unit after the edge.
module tb_cbm2_cycle_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [5:0] frame_len;
  logic [3:0] slot_fast;
  logic       pause;
  logic       reset_req;
  logic [1:0] slot;
  logic [1:0] sub;
  logic [3:0] slot_active, slot_first, slot_last;
  logic       padding, phase, refresh, io_cycle, sys_enable, pause_out, sys_reset, pixel_en;

  int errors = 0;
  int checks = 0;
  int clk_n  = 0;

  cbm2_cycle_sequencer dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .frame_len   (frame_len),
    .slot_fast   (slot_fast),
    .pause       (pause),
    .reset_req   (reset_req),
    .slot        (slot),
    .sub         (sub),
    .slot_active (slot_active),
    .slot_first  (slot_first),
    .slot_last   (slot_last),
    .padding     (padding),
    .phase       (phase),
    .refresh     (refresh),
    .io_cycle    (io_cycle),
    .sys_enable  (sys_enable),
    .pause_out   (pause_out),
    .sys_reset   (sys_reset),
    .pixel_en    (pixel_en)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @clk %0d: observed=%0h expected=%0h", tag, clk_n, obs, exp);
    end
  endtask

  task automatic go_to(input int target);
    while (clk_n < target) begin
      @(posedge clk_sys);
      clk_n++;
    end
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    frame_len = 6'd16;
    slot_fast = 4'b0000;
    pause     = 1'b0;
    reset_req = 1'b0;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    clk_n = 0;
    // Reset state
    check("rst_slot_active", 32'(slot_active), 32'h0);
    check("rst_sys_enable", 32'(sys_enable), 32'h0);
    check("rst_pause_out", 32'(pause_out), 32'h1);
    check("rst_sys_reset", 32'(sys_reset), 32'h1);
    check("rst_io_cycle", 32'(io_cycle), 32'h1);
    check("rst_refresh", 32'(refresh), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_padding", 32'(padding), 32'h0);
    check("rst_pixel_en", 32'(pixel_en), 32'h0);
    reset = 1'b0;

    // First frame: disabled, timing runs
    go_to(3);   check("dis_io_cyc3", 32'(io_cycle), 32'h1);
                check("dis_sub", 32'(sub), 32'h0);
    go_to(4);   check("dis_io_cyc4", 32'(io_cycle), 32'h0);
    go_to(15);  check("pre_en_sys_enable", 32'(sys_enable), 32'h0);
                check("pre_en_pause_out", 32'(pause_out), 32'h1);
                check("pre_en_refresh", 32'(refresh), 32'h0);
    go_to(16);  check("refresh_16", 32'(refresh), 32'h1);
                check("en_16", 32'(sys_enable), 32'h1);
                check("pause_out_16", 32'(pause_out), 32'h0);
                check("sys_reset_16", 32'(sys_reset), 32'h0);
                check("io_16", 32'(io_cycle), 32'h1);
    go_to(17);  check("refresh_17", 32'(refresh), 32'h0);
    go_to(19);  check("pix_19", 32'(pixel_en), 32'h1);
    go_to(20);  check("pix_20", 32'(pixel_en), 32'h0);
    go_to(23);  check("pix_23", 32'(pixel_en), 32'h1);

    // Phase-1 frame at 32: CPU slot qualified
    go_to(36);  check("cpu_active_36", 32'(slot_active), 32'h2);
                check("cpu_first_36", 32'(slot_first), 32'h2);
                check("slot_36", 32'(slot), 32'h1);
    go_to(38);  check("sub_38", 32'(sub), 32'h2);
    go_to(39);  check("cpu_last_39", 32'(slot_last), 32'h2);
    go_to(40);  check("cop_active_40", 32'(slot_active), 32'h4);
    go_to(52);  check("cpu_phase0_52", 32'(slot_active), 32'h0);
    // Refresh frame, phase 1: EXT slot reserved
    go_to(128); check("phase_128", 32'(phase), 32'h1);
                check("io_rfsh_128", 32'(io_cycle), 32'h0);
    go_to(143); check("refresh_143", 32'(refresh), 32'h0);
    go_to(144); check("refresh_144", 32'(refresh), 32'h1);

    // Pause mid-period
    go_to(145); pause = 1'b1;
    go_to(271); check("pause_en_271", 32'(sys_enable), 32'h1);
    go_to(272); check("pause_en_272", 32'(sys_enable), 32'h0);
                check("pause_out_272", 32'(pause_out), 32'h1);
                check("pause_phase_272", 32'(phase), 32'h0);
                check("pause_io_272", 32'(io_cycle), 32'h1);
                check("refresh_272", 32'(refresh), 32'h1);
    go_to(275); check("pause_io_275", 32'(io_cycle), 32'h1);
    go_to(276); check("pause_io_276", 32'(io_cycle), 32'h0);
                check("pause_active_276", 32'(slot_active), 32'h0);
                check("pause_slot_276", 32'(slot), 32'h0);
    go_to(280); pause = 1'b0;
    go_to(399); check("resume_en_399", 32'(sys_enable), 32'h0);
    go_to(400); check("resume_en_400", 32'(sys_enable), 32'h1);
                check("resume_phase_400", 32'(phase), 32'h0);

    // Fast CPU slot, 18-clock frames (change mid-frame)
    go_to(401); slot_fast = 4'b0010; frame_len = 6'd18;
    go_to(416); check("len_mid_pad_416", 32'(padding), 32'h0);
                check("len_mid_io_416", 32'(io_cycle), 32'h1);
    go_to(420); check("cpu_ph1_420", 32'(slot_active), 32'h2);
    go_to(431); check("pix_431", 32'(pixel_en), 32'h1);
    go_to(432); check("pad_432", 32'(padding), 32'h1);
                check("pad_active_432", 32'(slot_active), 32'h0);
                check("pad_slot_432", 32'(slot), 32'h0);
                check("pad_io_432", 32'(io_cycle), 32'h0);
    go_to(433); check("pad_433", 32'(padding), 32'h1);
                check("pix_433", 32'(pixel_en), 32'h0);
    go_to(434); check("pad_434", 32'(padding), 32'h0);
                check("phase_434", 32'(phase), 32'h0);
    go_to(435); check("pix_435", 32'(pixel_en), 32'h0);
    go_to(437); check("pix_437", 32'(pixel_en), 32'h1);
    go_to(438); check("cpu_fast_438", 32'(slot_active), 32'h2);

    // reset_req resynchronised to frame end
    go_to(440); reset_req = 1'b1;
    go_to(442); reset_req = 1'b0;
    go_to(443); check("sysrst_443", 32'(sys_reset), 32'h0);
    go_to(445); reset_req = 1'b1;
    go_to(451); check("sysrst_451", 32'(sys_reset), 32'h0);
    go_to(452); check("sysrst_452", 32'(sys_reset), 32'h1);
    go_to(455); reset_req = 1'b0;
    go_to(469); check("sysrst_469", 32'(sys_reset), 32'h1);
    go_to(470); check("sysrst_470", 32'(sys_reset), 32'h0);
                frame_len = 6'd10;

    // Clamp: 10 -> 16, frame 488..503
    go_to(498); check("clamp_slot_498", 32'(slot), 32'h2);
                check("clamp_sub_498", 32'(sub), 32'h2);
    go_to(503); check("clamp_slot_503", 32'(slot), 32'h3);
                check("clamp_sub_503", 32'(sub), 32'h3);
                check("clamp_pad_503", 32'(padding), 32'h0);
    go_to(504); check("clamp_wrap_504", 32'(io_cycle), 32'h1);

    // Reset mid-frame
    go_to(510); reset = 1'b1;
    go_to(511); reset = 1'b0;
                check("midrst_en", 32'(sys_enable), 32'h0);
                check("midrst_sysrst", 32'(sys_reset), 32'h1);
                check("midrst_io", 32'(io_cycle), 32'h1);
                check("midrst_pause_out", 32'(pause_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
